// File: rtl/seg7_scan_pkg.sv
// Shared types and constants for the seven-segment scan driver.
package seg7_scan_pkg;
  `include "seg7_defs.vh"

  localparam int NUM_DIG = 4;

  typedef logic [1:0] dig_t;
endpackage

// File: rtl/seg7_defs.vh
// Segment lookup table and active-level helpers for the seven-segment driver.
`ifndef SEG7_DEFS_VH
`define SEG7_DEFS_VH

// Active-high segment patterns, bit 6 = g .. bit 0 = a, indexed by hex value.
localparam logic [15:0][6:0] SEG_LUT = {
  7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
  7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
  7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
  7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
};

// Map an active-high pattern onto the pin polarity.
function automatic logic [6:0] seg_level(input logic [6:0] v, input logic active_low);
  return active_low ? ~v : v;
endfunction

function automatic logic [3:0] an_level(input logic [3:0] v, input logic active_low);
  return active_low ? ~v : v;
endfunction

function automatic logic bit_level(input logic v, input logic active_low);
  return active_low ? ~v : v;
endfunction

`endif

// File: rtl/seg7_hex_decode.sv
// Hex nibble to active-high seven-segment pattern.
module seg7_hex_decode (
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  import seg7_scan_pkg::*;

  assign seg = SEG_LUT[nib];
endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment driver with frame-latched input,
// inter-digit blanking and optional leading-zero suppression.
module seg7_scan #(
  parameter int CLK_DIV    = 50000,
  parameter int BLANK_CYC  = 2,
  parameter int LZ_BLANK   = 1,
  parameter int ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data,
  input  logic [3:0]  dp,
  input  logic        en,
  output logic [3:0]  AN,
  output logic [6:0]  seg,
  output logic        seg_P,
  output logic        frame_tick
);
  import seg7_scan_pkg::*;

  localparam int             CW        = $clog2(CLK_DIV);
  localparam logic [CW-1:0]  CNT_MAX   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]  BLANK_CNT = CW'(BLANK_CYC);
  localparam logic           POL_LOW   = (ACTIVE_LOW != 0);

  logic [CW-1:0] cnt;
  dig_t          dig;
  logic [15:0]   sh_data;
  logic [3:0]    sh_dp;

  logic [3:0]    nib;
  logic [6:0]    seg_hi;
  logic [3:0]    blank;
  logic          vis;
  logic          load;

  assign nib  = sh_data[{dig, 2'b00} +: 4];
  assign load = (cnt == '0) && (dig == '0);

  seg7_hex_decode u_dec (
    .nib (nib),
    .seg (seg_hi)
  );

  // Leading-zero mask: a digit blanks only if it and every digit above it is zero with no dp.
  always_comb begin
    blank = 4'b0000;
    if (LZ_BLANK != 0) begin
      blank[3] = (sh_data[15:12] == 4'h0) && !sh_dp[3];
      blank[2] = blank[3] && (sh_data[11:8] == 4'h0) && !sh_dp[2];
      blank[1] = blank[2] && (sh_data[7:4]  == 4'h0) && !sh_dp[1];
    end
  end

  assign vis = en && (cnt >= BLANK_CNT) && !blank[dig];

  // Prescaler, digit index and frame-boundary shadow load.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      dig        <= '0;
      sh_data    <= '0;
      sh_dp      <= '0;
      frame_tick <= 1'b0;
    end else begin
      if (cnt == CNT_MAX) begin
        cnt <= '0;
        dig <= dig + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      frame_tick <= load;
      if (load) begin
        sh_data <= data;
        sh_dp   <= dp;
      end
    end
  end

  // Registered pin drive from the pre-edge scan state.
  always_ff @(posedge clk) begin
    if (rst || !vis) begin
      AN    <= an_level(4'h0, POL_LOW);
      seg   <= seg_level(7'h00, POL_LOW);
      seg_P <= bit_level(1'b0, POL_LOW);
    end else begin
      AN    <= an_level(4'b0001 << dig, POL_LOW);
      seg   <= seg_level(seg_hi, POL_LOW);
      seg_P <= bit_level(sh_dp[dig], POL_LOW);
    end
  end
endmodule
